// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and types, also used by renderers.
package vga_timing_pkg;

    localparam int unsigned RGB_W     = 24;
    localparam int unsigned CNT_W     = 10;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        REG_VISIBLE,
        REG_FRONT,
        REG_SYNC,
        REG_BACK
    } region_e;

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// Renderer-facing address/pixel port plus the registered VGA pin bundle.
interface vga_sync_ctrl_if;
    import vga_timing_pkg::*;

    rgb_t pos_data;
    cnt_t pos_x;
    cnt_t pos_y;
    logic data_req;
    logic vga_hs;
    logic vga_vs;
    logic vga_de;
    rgb_t vga_rgb;
    logic frame_start;

    modport master (
        input  pos_data,
        output pos_x, pos_y, data_req,
        output vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );

    modport slave (
        output pos_data,
        input  pos_x, pos_y, data_req,
        input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with terminal count and region decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE = 640,
    parameter int unsigned FRONT   = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BACK    = 48
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    output cnt_t    cnt,
    output logic    tc_c,
    output region_e region_c
);

    localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int unsigned SYNC_START = VISIBLE + FRONT;
    localparam int unsigned BACK_START = SYNC_START + SYNC;

    assign tc_c = (cnt == CNT_W'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Regions are contiguous: visible, front porch, sync, back porch.
    always_comb begin
        region_c = REG_BACK;
        if (cnt < CNT_W'(VISIBLE)) begin
            region_c = REG_VISIBLE;
        end else if (cnt < CNT_W'(SYNC_START)) begin
            region_c = REG_FRONT;
        end else if (cnt < CNT_W'(BACK_START)) begin
            region_c = REG_SYNC;
        end
    end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing: combinational pixel request, registered syncs/DE/RGB aligned one cycle later.
module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic            vga_clk,
    input  logic            rst_n,
    vga_sync_ctrl_if.master bus
);

    cnt_t    h_cnt;
    cnt_t    v_cnt;
    logic    h_tc_c;
    logic    v_tc_c;
    region_e h_region_c;
    region_e v_region_c;
    logic    visible_c;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_cnt (
        .clk      (vga_clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .cnt      (h_cnt),
        .tc_c     (h_tc_c),
        .region_c (h_region_c)
    );

    // Vertical axis advances only on the horizontal wrap.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_cnt (
        .clk      (vga_clk),
        .rst_n    (rst_n),
        .en       (h_tc_c),
        .cnt      (v_cnt),
        .tc_c     (v_tc_c),
        .region_c (v_region_c)
    );

    assign visible_c    = (h_region_c == REG_VISIBLE) && (v_region_c == REG_VISIBLE);
    assign bus.data_req = visible_c;
    assign bus.pos_x    = visible_c ? h_cnt : '0;
    assign bus.pos_y    = visible_c ? v_cnt : '0;

    // Pin stage: everything registered from the same counter decode so it lines up with the pixel.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.vga_de      <= 1'b0;
            bus.vga_rgb     <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.vga_hs      <= (h_region_c != REG_SYNC);
            bus.vga_vs      <= (v_region_c != REG_SYNC);
            bus.vga_de      <= visible_c;
            bus.vga_rgb     <= visible_c ? bus.pos_data : '0;
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: full-size timing instance plus a tiny-timing instance for frame wraps and resets.
module tb_vga_sync_ctrl;
    import vga_timing_pkg::*;

    localparam int HV_B = 8, HF_B = 2, HS_B = 3, HB_B = 2;
    localparam int VV_B = 4, VF_B = 1, VS_B = 2, VB_B = 1;

    logic vga_clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    logic chk_en  = 1'b0;

    int passed = 0;
    int total  = 0;

    // Cycles since reset release and the pixel offered one cycle earlier, per instance.
    int   t_a = 0;
    int   t_b = 0;
    rgb_t pd_prev_a = '0;
    rgb_t pd_prev_b = '0;

    vga_sync_ctrl_if bus_a ();
    vga_sync_ctrl_if bus_b ();

    vga_sync_ctrl u_dut_a (
        .vga_clk (vga_clk),
        .rst_n   (rst_n_a),
        .bus     (bus_a)
    );

    vga_sync_ctrl #(
        .H_VISIBLE (HV_B), .H_FRONT (HF_B), .H_SYNC (HS_B), .H_BACK (HB_B),
        .V_VISIBLE (VV_B), .V_FRONT (VF_B), .V_SYNC (VS_B), .V_BACK (VB_B)
    ) u_dut_b (
        .vga_clk (vga_clk),
        .rst_n   (rst_n_b),
        .bus     (bus_b)
    );

    // Small instance renders a coordinate pattern so pixel/position alignment is visible.
    assign bus_b.pos_data = {bus_b.pos_y[7:0], 6'b0, bus_b.pos_x};

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        t_a       <= rst_n_a ? t_a + 1 : 0;
        t_b       <= rst_n_b ? t_b + 1 : 0;
        pd_prev_a <= bus_a.pos_data;
        pd_prev_b <= bus_b.pos_data;
    end

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    endtask

    // Expected outputs derived purely from elapsed cycles and the raster geometry.
    task automatic check_dut(input string tag, input int t,
                             input int hv, input int hf, input int hs, input int hb,
                             input int vv, input int vf, input int vs, input int vb,
                             input rgb_t pd_prev,
                             input logic req, input cnt_t px, input cnt_t py,
                             input logic hs_o, input logic vs_o, input logic de_o,
                             input rgb_t rgb_o, input logic fs_o);
        int ht, frame, p, h, v, q, hq, vq;
        logic e_req, e_de, e_hs, e_vs, e_fs;
        ht    = hv + hf + hs + hb;
        frame = ht * (vv + vf + vs + vb);
        p     = t % frame;
        h     = p % ht;
        v     = p / ht;
        e_req = (h < hv) && (v < vv);
        chk({tag, "_data_req"}, t, 32'(req), 32'(e_req));
        chk({tag, "_pos_x"}, t, 32'(px), e_req ? h : 0);
        chk({tag, "_pos_y"}, t, 32'(py), e_req ? v : 0);
        if (t == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
        end else begin
            q    = (t - 1) % frame;
            hq   = q % ht;
            vq   = q / ht;
            e_de = (hq < hv) && (vq < vv);
            e_hs = !((hq >= hv + hf) && (hq < hv + hf + hs));
            e_vs = !((vq >= vv + vf) && (vq < vv + vf + vs));
            e_fs = (q == 0);
        end
        chk({tag, "_vga_hs"}, t, 32'(hs_o), 32'(e_hs));
        chk({tag, "_vga_vs"}, t, 32'(vs_o), 32'(e_vs));
        chk({tag, "_vga_de"}, t, 32'(de_o), 32'(e_de));
        chk({tag, "_frame_start"}, t, 32'(fs_o), 32'(e_fs));
        chk({tag, "_vga_rgb"}, t, 32'(rgb_o), e_de ? 32'(pd_prev) : 32'd0);
    endtask

    always @(negedge vga_clk) begin
        if (chk_en) begin
            check_dut("a", t_a, int'(H_VISIBLE), int'(H_FRONT), int'(H_SYNC), int'(H_BACK),
                      int'(V_VISIBLE), int'(V_FRONT), int'(V_SYNC), int'(V_BACK), pd_prev_a,
                      bus_a.data_req, bus_a.pos_x, bus_a.pos_y, bus_a.vga_hs, bus_a.vga_vs,
                      bus_a.vga_de, bus_a.vga_rgb, bus_a.frame_start);
            check_dut("b", t_b, HV_B, HF_B, HS_B, HB_B, VV_B, VF_B, VS_B, VB_B, pd_prev_b,
                      bus_b.data_req, bus_b.pos_x, bus_b.pos_y, bus_b.vga_hs, bus_b.vga_vs,
                      bus_b.vga_de, bus_b.vga_rgb, bus_b.frame_start);

            // Hand-computed anchors for the full-size timing (pos_data fixed at 123456 early on).
            case (t_a)
                1:   begin chk("lit_a_fs_c1", t_a, 32'(bus_a.frame_start), 32'd1);
                           chk("lit_a_rgb_c1", t_a, 32'(bus_a.vga_rgb), 32'h123456); end
                640: chk("lit_a_rgb_c640", t_a, 32'(bus_a.vga_rgb), 32'h123456);
                641: begin chk("lit_a_rgb_c641", t_a, 32'(bus_a.vga_rgb), 32'h0);
                           chk("lit_a_de_c641", t_a, 32'(bus_a.vga_de), 32'd0); end
                656: chk("lit_a_hs_c656", t_a, 32'(bus_a.vga_hs), 32'd1);
                657: chk("lit_a_hs_c657", t_a, 32'(bus_a.vga_hs), 32'd0);
                752: chk("lit_a_hs_c752", t_a, 32'(bus_a.vga_hs), 32'd0);
                753: chk("lit_a_hs_c753", t_a, 32'(bus_a.vga_hs), 32'd1);
                799: chk("lit_a_req_c799", t_a, 32'(bus_a.data_req), 32'd0);
                800: begin chk("lit_a_posx_c800", t_a, 32'(bus_a.pos_x), 32'd0);
                           chk("lit_a_posy_c800", t_a, 32'(bus_a.pos_y), 32'd1);
                           chk("lit_a_req_c800", t_a, 32'(bus_a.data_req), 32'd1); end
                default: ;
            endcase

            // Anchors for the 15x8 raster (frame of 120 cycles, V sync on lines 5..6).
            case (t_b)
                1:   chk("lit_b_fs_c1", t_b, 32'(bus_b.frame_start), 32'd1);
                53:  chk("lit_b_rgb_last_pixel", t_b, 32'(bus_b.vga_rgb), 32'h030007);
                54:  chk("lit_b_rgb_blank", t_b, 32'(bus_b.vga_rgb), 32'h0);
                75:  chk("lit_b_vs_c75", t_b, 32'(bus_b.vga_vs), 32'd1);
                76:  chk("lit_b_vs_c76", t_b, 32'(bus_b.vga_vs), 32'd0);
                105: chk("lit_b_vs_c105", t_b, 32'(bus_b.vga_vs), 32'd0);
                106: chk("lit_b_vs_c106", t_b, 32'(bus_b.vga_vs), 32'd1);
                119: begin chk("lit_b_req_c119", t_b, 32'(bus_b.data_req), 32'd0);
                           chk("lit_b_posx_c119", t_b, 32'(bus_b.pos_x), 32'd0); end
                120: begin chk("lit_b_wrap_posx", t_b, 32'(bus_b.pos_x), 32'd0);
                           chk("lit_b_wrap_posy", t_b, 32'(bus_b.pos_y), 32'd0);
                           chk("lit_b_wrap_req", t_b, 32'(bus_b.data_req), 32'd1); end
                121: chk("lit_b_fs_c121", t_b, 32'(bus_b.frame_start), 32'd1);
                241: chk("lit_b_fs_c241", t_b, 32'(bus_b.frame_start), 32'd1);
                default: ;
            endcase
        end
    end

    initial begin
        int  rst_hold;
        bit  did_mid;
        rst_hold = 0;
        did_mid  = 1'b0;
        bus_a.pos_data = 24'h123456;
        repeat (3) @(posedge vga_clk);
        #2;
        chk_en = 1'b1;
        @(posedge vga_clk);
        #2;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        for (int i = 0; i < 2600; i++) begin
            @(posedge vga_clk);
            #2;
            if (t_a > 700) bus_a.pos_data = rgb_t'($urandom);
            // Mid-frame abort on the small raster at h=5, v=2, then sparse random resets.
            if (!did_mid && t_b == 275) begin
                rst_hold = 3;
                did_mid  = 1'b1;
            end else if (rst_hold == 0 && i > 600 && $urandom_range(0, 199) == 0) begin
                rst_hold = $urandom_range(1, 3);
            end
            if (rst_hold > 0) begin
                rst_n_b = 1'b0;
                rst_hold--;
            end else begin
                rst_n_b = 1'b1;
            end
        end
        @(negedge vga_clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixels (line total 800).
REQ-003 Parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical widths in lines (frame total 525).
REQ-004 vga_clk  input  1  pixel clock, 25 MHz nominal; single clock domain; reset is synchronous and active-low.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 pos_data  input  24  RGB888 pixel from the renderer for the current pos_x/pos_y, combinational, same cycle.
REQ-007 pos_x  output  10  requested pixel column, 0..639.
REQ-008 pos_y  output  10  requested pixel row, 0..479.
REQ-009 data_req  output  1  high when pos_x/pos_y address a visible pixel.
REQ-010 vga_hs  output  1  horizontal sync, active low.
REQ-011 vga_vs  output  1  vertical sync, active low.
REQ-012 vga_de  output  1  display enable aligned with vga_rgb.
REQ-013 vga_rgb  output  24  registered pixel to the DAC/pins.
REQ-014 frame_start  output  1  one-cycle pulse at the first cycle of each frame.

Function
REQ-015 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment only when h_cnt wraps, count 0..524, and wrap to 0.
REQ-016 Region order per axis: visible from 0, then front porch, sync, back porch (H sync at h_cnt 656..751; V sync at v_cnt 490..491).
REQ-017 data_req SHALL be 1 iff h_cnt<640 and v_cnt<480, combinational from the counters.
REQ-018 pos_x SHALL equal h_cnt and pos_y SHALL equal v_cnt while data_req=1; otherwise both SHALL be 0.
REQ-019 vga_rgb SHALL register pos_data when data_req=1 and register 24'h000000 otherwise: one-cycle latency from address to pixel.
REQ-020 vga_hs, vga_vs and vga_de SHALL be registered from the same-cycle counter decode so they align with vga_rgb (one cycle after the counters).
REQ-021 frame_start SHALL be registered and high for exactly one cycle, the cycle in which vga_rgb carries pixel (0,0).
REQ-022 Counter widths SHALL be 10 bits; there is no overflow path because wrap occurs at 799 and 524.
REQ-023 Back-to-back frames SHALL have no gap: the cycle after h_cnt=799, v_cnt=524 is h_cnt=0, v_cnt=0.

Reset
REQ-024 While rst_n=0 at a vga_clk edge: h_cnt=0, v_cnt=0, vga_hs=1, vga_vs=1, vga_de=0, vga_rgb=0, frame_start=0.
REQ-025 An asserted reset mid-frame SHALL abort the frame; the first edge with rst_n=1 begins a new frame at (0,0), and frame_start pulses one cycle later.
REQ-026 The block SHALL have no asynchronous reset path.

Structure
REQ-027 Timing constants (visible, porch, sync, total per axis) and the RGB888 width SHALL live in shared package vga_timing_pkg for use by renderers.
REQ-028 One sub-module, vga_axis_counter (wrap counter with terminal-count output and region decode), SHALL be instantiated once for H and once for V.

Verification
REQ-029 Reset release, pos_data=24'h123456 constant -> frame_start at cycle 1; vga_rgb=24'h123456 for cycles 1..640; vga_rgb=0 and vga_de=0 at cycle 641.
REQ-030 Run one line -> vga_hs low exactly for cycles 657..752 after release (96 cycles); the line period is 800 cycles.
REQ-031 Run full frame -> vga_vs low for 1600 cycles starting at line 490; frame_start period is 420000 cycles.
REQ-032 pos_data driven as {pos_y[7:0],6'b0,pos_x} -> vga_rgb at row 479, col 639 equals that pattern, one cycle delayed; pos_x/pos_y read 0 in blanking.
REQ-033 Assert rst_n=0 at h_cnt=300, v_cnt=200 for 3 cycles -> outputs hold reset values, then restart at (0,0) with frame_start one cycle after release.
REQ-034 Boundary: at h_cnt=799, v_cnt=524 -> next cycle counters read 0/0 and data_req=1.
